// File: rtl/next_pc_unit.sv
// next_pc_unit
//   Owns the architectural PC and picks the next fetch address from four sources:
//   sequential, branch/JAL target, JALR target and trap vector.
//   A small return-address stack (RAS) predicts JALR returns. The RAS only produces
//   a prediction; it never changes PCSel or pc.
//
// Ports
//   clk, rst_n          core clock, asynchronous active-low reset
//   stall               hold pc, RAS and ras_overflow this cycle
//   trap, trap_vec      trap redirect (highest priority)
//   Branch, take_branch conditional branch and its resolved condition
//   Jal, Jalr           jump instructions
//   rd_link, rs1_link   the link register (x1/x5) is used as rd / rs1
//   imm_target          PC+imm target (branch, JAL)
//   alu_target          rs1+imm target (JALR); bit 0 is cleared here
//   ras_flush           empty the RAS, regardless of stall
//   pc, pc_plus4        current PC and PC+4 (wraps modulo 2^XLEN)
//   PCSel               00 +4, 01 imm_target, 10 alu_target, 11 trap_vec
//   ras_top, ras_valid  predicted return address and RAS non-empty flag
//   ras_overflow        sticky flag: a push happened while the RAS was full
//   ras_underflow       one-cycle pulse: a pop was attempted while the RAS was empty
module next_pc_unit #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter int               RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            Branch,
    input  logic            take_branch,
    input  logic            Jal,
    input  logic            Jalr,
    input  logic            rd_link,
    input  logic            rs1_link,
    input  logic [XLEN-1:0] imm_target,
    input  logic [XLEN-1:0] alu_target,
    input  logic            ras_flush,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [1:0]      PCSel,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_valid,
    output logic            ras_overflow,
    output logic            ras_underflow
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(RAS_DEPTH);

    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]   top_ptr;
    logic [CW-1:0]   ras_count;
    logic [XLEN-1:0] next_pc;

    logic ras_en;
    logic op_push;
    logic op_pop;
    logic op_replace;
    logic ras_empty;
    logic ras_full;

    assign pc_plus4 = pc + XLEN'(4);

    always_comb begin
        PCSel   = 2'b00;
        next_pc = pc_plus4;
        if (trap) begin
            PCSel   = 2'b11;
            next_pc = trap_vec;
        end else if (Jalr) begin
            PCSel   = 2'b10;
            next_pc = {alu_target[XLEN-1:1], 1'b0};
        end else if (Jal || (Branch && take_branch)) begin
            PCSel   = 2'b01;
            next_pc = imm_target;
        end
    end

    // A trap squashes the instruction, so it also squashes its RAS side effect.
    assign ras_en     = !stall && !trap;
    assign op_replace = Jalr && rd_link && rs1_link;
    assign op_push    = (Jal && rd_link) || (Jalr && rd_link && !rs1_link);
    assign op_pop     = Jalr && rs1_link && !rd_link;
    assign ras_empty  = (ras_count == '0);
    assign ras_full   = (ras_count == FULL_COUNT);

    assign ras_top   = ras_mem[top_ptr];
    assign ras_valid = !ras_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc            <= RESET_PC;
            top_ptr       <= '0;
            ras_count     <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
        end else begin
            ras_underflow <= 1'b0;

            if (!stall) begin
                pc <= next_pc;
            end

            if (ras_flush) begin
                top_ptr      <= '0;
                ras_count    <= '0;
                ras_overflow <= 1'b0;
            end else if (ras_en) begin
                if (op_replace && !ras_empty) begin
                    ras_mem[top_ptr] <= pc_plus4;
                end else if (op_push || op_replace) begin
                    // Circular buffer: when full, the slot after top holds the oldest entry.
                    ras_mem[top_ptr + PW'(1)] <= pc_plus4;
                    top_ptr                   <= top_ptr + PW'(1);
                    if (ras_full) begin
                        ras_overflow <= 1'b1;
                    end else begin
                        ras_count <= ras_count + CW'(1);
                    end
                end else if (op_pop) begin
                    if (ras_empty) begin
                        ras_underflow <= 1'b1;
                    end else begin
                        top_ptr   <= top_ptr - PW'(1);
                        ras_count <= ras_count - CW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_next_pc_unit.sv
module tb_next_pc_unit;

    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          RAS_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, trap, Branch, take_branch, Jal, Jalr, rd_link, rs1_link, ras_flush;
    logic [31:0] trap_vec, imm_target, alu_target;
    logic [31:0] pc, pc_plus4, ras_top;
    logic [1:0]  PCSel;
    logic        ras_valid, ras_overflow, ras_underflow;

    next_pc_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .RAS_DEPTH(RAS_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .trap(trap), .trap_vec(trap_vec),
        .Branch(Branch), .take_branch(take_branch), .Jal(Jal), .Jalr(Jalr),
        .rd_link(rd_link), .rs1_link(rs1_link), .imm_target(imm_target),
        .alu_target(alu_target), .ras_flush(ras_flush), .pc(pc), .pc_plus4(pc_plus4),
        .PCSel(PCSel), .ras_top(ras_top), .ras_valid(ras_valid),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [1:0]  sel;
        logic        valid;
        logic [31:0] top;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;

    // Reference model: PC value, RAS as a list of return addresses (newest last).
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_ovf;
    logic        m_unf;

    task automatic model_reset();
        m_pc  = RESET_PC;
        m_ras.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic clear_inputs();
        stall = 0; trap = 0; Branch = 0; take_branch = 0; Jal = 0; Jalr = 0;
        rd_link = 0; rs1_link = 0; ras_flush = 0;
        trap_vec = 32'h0; imm_target = 32'h0; alu_target = 32'h0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic ras_push(input logic [31:0] ret);
        m_ras.push_back(ret);
        if (m_ras.size() > RAS_DEPTH) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
        end
    endtask

    // Called right after a falling edge with inputs applied: records what the DUT
    // must show now, advances the model across the next rising edge, then waits.
    task automatic step();
        exp_t        e;
        logic [31:0] p4;
        logic [31:0] npc;
        logic [1:0]  sel;
        logic        unf_next;

        p4 = m_pc + 32'd4;
        if (trap)                           begin sel = 2'd3; npc = trap_vec; end
        else if (Jalr)                      begin sel = 2'd2; npc = alu_target & 32'hFFFF_FFFE; end
        else if (Jal || (Branch && take_branch)) begin sel = 2'd1; npc = imm_target; end
        else                                begin sel = 2'd0; npc = p4; end

        e.pc = m_pc; e.pc_plus4 = p4; e.sel = sel;
        e.valid = (m_ras.size() != 0);
        e.top   = (m_ras.size() != 0) ? m_ras[$] : 32'h0;
        e.ovf = m_ovf; e.unf = m_unf;
        exp_q.push_back(e);

        unf_next = 1'b0;
        if (ras_flush) begin
            m_ras.delete();
            m_ovf = 1'b0;
        end else if (!stall && !trap) begin
            if (Jalr && rd_link && rs1_link) begin
                if (m_ras.size() != 0) m_ras[$] = p4;
                else ras_push(p4);
            end else if ((Jal && rd_link) || (Jalr && rd_link)) begin
                ras_push(p4);
            end else if (Jalr && rs1_link) begin
                if (m_ras.size() != 0) void'(m_ras.pop_back());
                else unf_next = 1'b1;
            end
        end
        m_unf = unf_next;
        if (!stall) m_pc = npc;
        @(negedge clk);
    endtask

    // Monitor: every cycle the DUT presents its outputs, compare with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pc", pc, e.pc);
                check("pc_plus4", pc_plus4, e.pc_plus4);
                check("PCSel", {30'd0, PCSel}, {30'd0, e.sel});
                check("ras_valid", {31'd0, ras_valid}, {31'd0, e.valid});
                if (e.valid) check("ras_top", ras_top, e.top);
                check("ras_overflow", {31'd0, ras_overflow}, {31'd0, e.ovf});
                check("ras_underflow", {31'd0, ras_underflow}, {31'd0, e.unf});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        model_reset();
        rst_n = 1'b0;
        #1;
        check("reset_pc", pc, RESET_PC);
        check("reset_ras_valid", {31'd0, ras_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch: 0, 4, 8
        repeat (2) step();
        // Taken branch at pc=8 to 0x40, then not-taken branch at 0x40
        Branch = 1; take_branch = 1; imm_target = 32'h40; step();
        take_branch = 0; step();
        clear_inputs();
        // JALR target clears bit 0; then same with trap winning and RAS untouched
        Jalr = 1; rd_link = 1; alu_target = 32'h0000_0103; step();
        trap = 1; trap_vec = 32'h100; step();
        clear_inputs();
        // Flush the one entry pushed by the JALR above, then jump to 0
        ras_flush = 1; Jal = 1; imm_target = 32'h0; step();
        clear_inputs();

        // Five pushes at 0,0x10,..,0x40 overflow a depth-4 stack
        for (int i = 0; i < 5; i++) begin
            Jal = 1; rd_link = 1; imm_target = 32'h10 * (i + 1); step();
            clear_inputs();
            imm_target = 32'h10 * (i + 1);
            while (m_pc != imm_target) step();
        end
        // Four pops then one on an empty stack
        for (int i = 0; i < 5; i++) begin
            Jalr = 1; rs1_link = 1; alu_target = 32'h200; step();
        end
        clear_inputs();
        step(); step();

        // Stalled JAL held for two cycles, then released
        Jal = 1; rd_link = 1; imm_target = 32'h80;
        stall = 1; step(); step();
        stall = 0; step();
        clear_inputs();
        // Wrap of pc_plus4 at the top of the address space
        Jal = 1; imm_target = 32'hFFFF_FFFC; step();
        rd_link = 1; imm_target = 32'h0; step();
        clear_inputs();
        step();

        // Two pushes then a flush concurrent with a push
        Jal = 1; rd_link = 1; imm_target = 32'h300; step();
        imm_target = 32'h400; step();
        ras_flush = 1; imm_target = 32'h500; step();
        clear_inputs();
        step();

        // Randomized traffic with one-hot instruction types
        for (int n = 0; n < 400; n++) begin
            int kind;
            clear_inputs();
            kind        = $urandom_range(0, 4);
            Branch      = (kind == 1);
            take_branch = $urandom_range(0, 1);
            Jal         = (kind == 2);
            Jalr        = (kind >= 3);
            rd_link     = $urandom_range(0, 1);
            rs1_link    = $urandom_range(0, 1);
            stall       = ($urandom_range(0, 4) == 0);
            trap        = ($urandom_range(0, 15) == 0);
            ras_flush   = ($urandom_range(0, 19) == 0);
            trap_vec    = $urandom & 32'hFFFF_FFFC;
            imm_target  = $urandom & 32'hFFFF_FFFC;
            alu_target  = $urandom;
            step();
        end
        clear_inputs();
        step();

        // Reset asserted in the middle of a cycle takes effect without a clock edge
        Jal = 1; imm_target = 32'h700; step();
        clear_inputs();
        Jal = 1; rd_link = 1; imm_target = 32'h800; step();
        clear_inputs();
        #7;
        rst_n = 1'b0;
        #1;
        check("async_reset_pc", pc, RESET_PC);
        check("async_reset_ras_valid", {31'd0, ras_valid}, 32'd0);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        step(); step();

        @(negedge clk);
        #5;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
